// File: rtl/button_conditioner.sv
// Button input stage: synchronises and debounces the active-low board buttons.
// It presents active-high levels and sticky press/release flags to the CPU.
module button_conditioner #(
  parameter int WIDTH          = 8,
  parameter int TICK_DIV       = 27000,
  parameter int DEBOUNCE_TICKS = 5
) (
  input  logic             clk,
  input  logic             n_reset,
  input  logic [WIDTH-1:0] n_btn,
  input  logic [WIDTH-1:0] clear_mask,
  output logic [WIDTH-1:0] buttons,
  output logic [WIDTH-1:0] pressed,
  output logic [WIDTH-1:0] released,
  output logic             any_pressed,
  output logic             tick
);

  localparam int DW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int CW = $clog2(DEBOUNCE_TICKS + 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(TICK_DIV - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_TICKS - 1);

  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;
  logic [WIDTH-1:0] lvl;
  logic [WIDTH-1:0] btn_next;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic [DW-1:0]    div;
  logic [CW-1:0]    cnt      [WIDTH];
  logic [CW-1:0]    cnt_next [WIDTH];

  assign lvl         = ~sync2;
  assign any_pressed = |pressed;
  assign rise        = btn_next & ~buttons;
  assign fall        = ~btn_next & buttons;

  // Any agreeing cycle restarts the count, so a single bounce defers acceptance.
  always_comb begin
    btn_next = buttons;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_next[i] = '0;
      if (lvl[i] != buttons[i]) begin
        cnt_next[i] = cnt[i];
        if (tick) begin
          if (cnt[i] == CNT_LAST) begin
            btn_next[i] = lvl[i];
            cnt_next[i] = '0;
          end else begin
            cnt_next[i] = cnt[i] + CW'(1);
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      sync1    <= '1;
      sync2    <= '1;
      div      <= '0;
      tick     <= 1'b0;
      buttons  <= '0;
      pressed  <= '0;
      released <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      sync1    <= n_btn;
      sync2    <= sync1;
      div      <= (div == DIV_LAST) ? '0 : div + DW'(1);
      tick     <= (div == DIV_LAST);
      buttons  <= btn_next;
      // A set on the same edge as a clear wins.
      pressed  <= (pressed & ~clear_mask) | rise;
      released <= (released & ~clear_mask) | fall;
      for (int i = 0; i < WIDTH; i++) begin
        cnt[i] <= cnt_next[i];
      end
    end
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Scoreboard bench for button_conditioner with TICK_DIV=4, DEBOUNCE_TICKS=3.
// Stimulus pushes expected output changes; a negedge monitor pops and compares them.
module tb_button_conditioner;

  logic       clk = 1'b0;
  logic       n_reset;
  logic [7:0] n_btn;
  logic [7:0] clear_mask;
  logic [7:0] buttons;
  logic [7:0] pressed;
  logic [7:0] released;
  logic       any_pressed;
  logic       tick;

  button_conditioner #(.WIDTH(8), .TICK_DIV(4), .DEBOUNCE_TICKS(3)) dut (
    .clk         (clk),
    .n_reset     (n_reset),
    .n_btn       (n_btn),
    .clear_mask  (clear_mask),
    .buttons     (buttons),
    .pressed     (pressed),
    .released    (released),
    .any_pressed (any_pressed),
    .tick        (tick)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         c;
    logic [7:0] b;
    logic [7:0] p;
    logic [7:0] r;
  } ev_t;

  ev_t  eq[$];
  int   tq[$];
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;
  ev_t  e_mon;
  int   t_mon;
  logic [23:0] prev = '0;

  // cyc = number of rising edges since the last reset release
  always @(posedge clk) begin
    if (!n_reset) cyc <= 0;
    else          cyc <= cyc + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic push_ev(input int c, input logic [7:0] b, input logic [7:0] p,
                         input logic [7:0] r);
    ev_t e;
    e.c = c; e.b = b; e.p = p; e.r = r;
    eq.push_back(e);
  endtask

  always @(negedge clk) begin
    if (!n_reset) begin
      prev = '0;
    end else begin
      if (tq.size() > 0 && tq[0] < cyc) begin
        t_mon = tq.pop_front();
        check("tick_missing", cyc, t_mon);
      end
      if (tick === 1'b1 && tq.size() > 0) begin
        t_mon = tq.pop_front();
        check("tick_cycle", cyc, t_mon);
      end
      if ({buttons, pressed, released} !== prev) begin
        if (eq.size() == 0) begin
          check("unexpected_change", {8'h0, buttons, pressed, released}, {8'h0, prev});
        end else begin
          e_mon = eq.pop_front();
          check("ev_cycle", cyc, e_mon.c);
          check("buttons", buttons, e_mon.b);
          check("pressed", pressed, e_mon.p);
          check("released", released, e_mon.r);
          check("any_pressed", any_pressed, |e_mon.p);
        end
        prev = {buttons, pressed, released};
      end
    end
  end

  initial begin
    #20000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    n_btn      = 8'hFF;
    clear_mask = 8'h00;
    n_reset    = 1'b1;
    #2 n_reset = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_buttons", buttons, 8'h00);
    check("rst_pressed", pressed, 8'h00);
    check("rst_released", released, 8'h00);
    check("rst_any", any_pressed, 1'b0);
    check("rst_tick", tick, 1'b0);
    n_reset = 1'b1;
    for (int k = 1; k <= 5; k++) tq.push_back(4 * k);

    // press channel 0
    wait_cyc(20);
    n_btn[0] = 1'b0;
    push_ev(33, 8'h01, 8'h01, 8'h00);

    // bounce on channel 2: one high cycle restarts the count
    wait_cyc(36);
    n_btn[2] = 1'b0;
    wait_cyc(42);
    n_btn[2] = 1'b1;
    wait_cyc(43);
    n_btn[2] = 1'b0;
    push_ev(57, 8'h05, 8'h05, 8'h00);

    // release channel 0, then clear its flags
    wait_cyc(60);
    n_btn[0] = 1'b1;
    push_ev(73, 8'h04, 8'h05, 8'h01);
    wait_cyc(76);
    clear_mask = 8'h01;
    push_ev(77, 8'h04, 8'h04, 8'h00);
    wait_cyc(77);
    clear_mask = 8'h00;

    // channel 5 rises on the same edge its clear bit is applied
    wait_cyc(80);
    n_btn[5] = 1'b0;
    push_ev(93, 8'h24, 8'h24, 8'h00);
    wait_cyc(92);
    clear_mask = 8'h20;
    wait_cyc(93);
    clear_mask = 8'h00;

    // channel 7 counting; reset while counter=2, divider=3
    wait_cyc(100);
    n_btn[7] = 1'b0;
    wait_cyc(111);
    n_reset = 1'b0;
    #1;
    check("mid_rst_buttons", buttons, 8'h00);
    check("mid_rst_pressed", pressed, 8'h00);
    check("mid_rst_released", released, 8'h00);
    check("mid_rst_any", any_pressed, 1'b0);
    check("mid_rst_tick", tick, 1'b0);
    repeat (3) @(negedge clk);
    n_reset = 1'b1;
    for (int k = 1; k <= 3; k++) tq.push_back(4 * k);
    push_ev(13, 8'hA4, 8'hA4, 8'h00);

    wait_cyc(20);
    check("events_left", eq.size(), 0);
    check("ticks_left", tq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
